// File: rtl/fetch_stage.sv
// fetch_stage: credit-limited instruction fetch, in-order response FIFO and IF/ID register.
// Define FETCH_ILLEGAL_CHK_EN to turn words with rdata[1:0] != 2'b11 into NOPs flagged on illegal_o.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [31:0] instr_pc4_o,
`ifdef FETCH_ILLEGAL_CHK_EN
  output logic        illegal_o,
`endif
  output logic        instr_valid_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [AW+1:0] DEPTH = (AW+2)'(FIFO_DEPTH);
  logic [31:0] pc_q, pc_d;
  logic epoch_q, epoch_d;
  logic [31:0] pq_pc_q [FIFO_DEPTH], pq_pc_d [FIFO_DEPTH];
  logic pq_ep_q [FIFO_DEPTH], pq_ep_d [FIFO_DEPTH];
  logic [AW-1:0] pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
  logic [AW:0] pq_cnt_q, pq_cnt_d;
  logic [31:0] fi_data_q [FIFO_DEPTH], fi_data_d [FIFO_DEPTH];
  logic [31:0] fi_pc_q [FIFO_DEPTH], fi_pc_d [FIFO_DEPTH];
  logic [AW-1:0] fi_wr_q, fi_wr_d, fi_rd_q, fi_rd_d;
  logic [AW:0] fi_cnt_q, fi_cnt_d;
  logic [31:0] instr_q, instr_d, ipc_q, ipc_d;
  logic valid_q, valid_d;
`ifdef FETCH_ILLEGAL_CHK_EN
  logic ill_q, ill_d;
`endif
  logic xfer, rsp_ok, fi_empty, load, pop, bypass, push, have, bad;
  logic [31:0] src_data, src_pc;
  // Credits cover both in-flight requests and buffered words, so the FIFO can never overflow.
  assign imem_req_o  = rst_n && !redirect_i && ({1'b0, pq_cnt_q} + {1'b0, fi_cnt_q} < DEPTH);
  assign imem_addr_o = pc_q;
  assign xfer        = imem_req_o && imem_gnt_i;
  assign fi_empty    = fi_cnt_q == '0;
  assign rsp_ok      = imem_rvalid_i && !redirect_i && pq_ep_q[pq_rd_q] == epoch_q;
  assign load        = !stall_i;
  assign pop         = load && !fi_empty;
  assign bypass      = load && fi_empty && rsp_ok;
  assign push        = rsp_ok && !bypass;
  assign have        = !fi_empty || rsp_ok;
  assign src_data    = fi_empty ? imem_rdata_i : fi_data_q[fi_rd_q];
  assign src_pc      = fi_empty ? pq_pc_q[pq_rd_q] : fi_pc_q[fi_rd_q];
  always_comb begin
    pc_d = redirect_i ? (redirect_pc_i & 32'hFFFF_FFFC) : xfer ? pc_q + 32'd4 : pc_q;
    epoch_d = epoch_q ^ redirect_i;
    pq_pc_d = pq_pc_q;
    pq_ep_d = pq_ep_q;
    if (xfer) begin
      pq_pc_d[pq_wr_q] = pc_q;
      pq_ep_d[pq_wr_q] = epoch_q;
    end
    pq_wr_d = pq_wr_q + AW'(xfer);
    pq_rd_d = pq_rd_q + AW'(imem_rvalid_i);
    pq_cnt_d = pq_cnt_q + (AW+1)'(xfer) - (AW+1)'(imem_rvalid_i);
    fi_data_d = fi_data_q;
    fi_pc_d = fi_pc_q;
    if (push) begin
      fi_data_d[fi_wr_q] = imem_rdata_i;
      fi_pc_d[fi_wr_q] = pq_pc_q[pq_rd_q];
    end
    fi_wr_d = redirect_i ? '0 : fi_wr_q + AW'(push);
    fi_rd_d = redirect_i ? '0 : fi_rd_q + AW'(pop);
    fi_cnt_d = redirect_i ? '0 : fi_cnt_q + (AW+1)'(push) - (AW+1)'(pop);
`ifdef FETCH_ILLEGAL_CHK_EN
    bad = src_data[1:0] != 2'b11;
    ill_d = redirect_i ? 1'b0 : load ? have && bad : ill_q;
`else
    bad = 1'b0;
`endif
    instr_d = redirect_i ? NOP : load ? (have && !bad ? src_data : NOP) : instr_q;
    ipc_d = !redirect_i && load && have ? src_pc : ipc_q;
    valid_d = redirect_i ? 1'b0 : load ? have : valid_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      epoch_q  <= 1'b0;
      pq_wr_q  <= '0;
      pq_rd_q  <= '0;
      pq_cnt_q <= '0;
      fi_wr_q  <= '0;
      fi_rd_q  <= '0;
      fi_cnt_q <= '0;
      instr_q  <= NOP;
      ipc_q    <= '0;
      valid_q  <= 1'b0;
`ifdef FETCH_ILLEGAL_CHK_EN
      ill_q    <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      epoch_q  <= epoch_d;
      pq_wr_q  <= pq_wr_d;
      pq_rd_q  <= pq_rd_d;
      pq_cnt_q <= pq_cnt_d;
      fi_wr_q  <= fi_wr_d;
      fi_rd_q  <= fi_rd_d;
      fi_cnt_q <= fi_cnt_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
`ifdef FETCH_ILLEGAL_CHK_EN
      ill_q    <= ill_d;
`endif
    end
  end
  // Storage entries are qualified by the pointers and counts, so they need no reset.
  always_ff @(posedge clk) begin
    pq_pc_q   <= pq_pc_d;
    pq_ep_q   <= pq_ep_d;
    fi_data_q <= fi_data_d;
    fi_pc_q   <= fi_pc_d;
  end
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign instr_pc4_o   = ipc_q + 32'd4;
  assign instr_valid_o = valid_q;
`ifdef FETCH_ILLEGAL_CHK_EN
  assign illegal_o     = ill_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed cycle-by-cycle checks of fetch_stage against a small in-order memory model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst_n = 1'b0, redirect_i = 1'b0, stall_i = 1'b0;
  logic imem_gnt_i = 1'b1, imem_rvalid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, imem_rdata_i = '0;
  logic imem_req_o, instr_valid_o;
  logic [31:0] imem_addr_o, instr_o, instr_pc_o, instr_pc4_o;
`ifdef FETCH_ILLEGAL_CHK_EN
  logic illegal_o;
`endif
  int errors = 0, checks = 0, cyc = 0;
  bit mem_hold = 1'b0, ovf = 1'b0;
  logic [31:0] bad_addr = 32'hDEAD_BEE0;
  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t mq[$];
  req_t r_new;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .stall_i(stall_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_pc4_o(instr_pc4_o),
`ifdef FETCH_ILLEGAL_CHK_EN
    .illegal_o(illegal_o),
`endif
    .instr_valid_o(instr_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == bad_addr) ? 32'h0000_0001 : {a[31:2], 2'b11};
  endfunction

  // In-order memory: answers one cycle after grant unless mem_hold stalls it.
  always @(posedge clk) begin
    if (!rst_n) mq.delete();
    else begin
      if (imem_rvalid_i) void'(mq.pop_front());
      if (imem_req_o && imem_gnt_i) begin
        r_new.addr = imem_addr_o;
        r_new.due = cyc + 1;
        mq.push_back(r_new);
      end
      if (dut.fi_cnt_q == 2 && dut.push && !dut.pop) ovf = 1'b1;
    end
    cyc++;
    #2;
    imem_rvalid_i = rst_n && !mem_hold && mq.size() > 0 && mq[0].due <= cyc;
    imem_rdata_i = imem_rvalid_i ? word(mq[0].addr) : 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic see(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(instr_valid_o), 32'(v));
    if (v) begin
      chk({tag, "_pc"}, instr_pc_o, pc);
      chk({tag, "_pc4"}, instr_pc4_o, pc + 32'd4);
      chk({tag, "_instr"}, instr_o, word(pc));
    end else chk({tag, "_nop"}, instr_o, NOP);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_req"}, 32'(imem_req_o), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
    chk({tag, "_instr"}, instr_o, NOP);
    chk({tag, "_pc"}, instr_pc_o, 32'd0);
    chk({tag, "_pc4"}, instr_pc4_o, 32'd4);
`ifdef FETCH_ILLEGAL_CHK_EN
    chk({tag, "_ill"}, 32'(illegal_o), 32'd0);
`endif
  endtask

  initial begin
    repeat (3) tick();
    reset_vals("rst");
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("t1_addr", imem_addr_o, 32'(4 * i));
      see("t1", i >= 2, 32'(4 * (i - 2)));
    end
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_req_full", 32'(imem_req_o), 32'd0);
      see("t2_hold", 1'b1, 32'd16);
    end
    stall_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      see("t2_rel", 1'b1, 32'(16 + 4 * i));
    end
    chk("t2_addr", imem_addr_o, 32'd40);
    mem_hold = 1'b1;
    tick();
    see("t3_i", 1'b1, 32'd36);
    chk("t3_req_i", 32'(imem_req_o), 32'd1);
    chk("t3_addr_i", imem_addr_o, 32'd44);
    tick();
    see("t3_j", 1'b0, 32'd0);
    chk("t3_req_out2", 32'(imem_req_o), 32'd0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    mem_hold = 1'b0;
    tick();
    redirect_i = 1'b0;
    see("t3_k", 1'b0, 32'd0);
    chk("t3_req_k", 32'(imem_req_o), 32'd0);
    chk("t3_addr_k", imem_addr_o, 32'h100);
    tick();
    see("t3_l", 1'b0, 32'd0);
    chk("t3_req_l", 32'(imem_req_o), 32'd1);
    tick();
    see("t3_m", 1'b0, 32'd0);
    tick();
    see("t3_n", 1'b1, 32'h100);
    tick();
    see("t3_o", 1'b1, 32'h104);
    stall_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFA;
    tick();
    see("t4_p", 1'b0, 32'd0);
    chk("t4_addr", imem_addr_o, 32'hFFFF_FFF8);
    stall_i = 1'b0;
    redirect_i = 1'b0;
    tick();
    see("t5_q", 1'b0, 32'd0);
    chk("t5_addr_q", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    see("t5_r", 1'b1, 32'hFFFF_FFF8);
    chk("t5_addr_wrap", imem_addr_o, 32'h0);
    tick();
    see("t5_s", 1'b1, 32'hFFFF_FFFC);
    tick();
    see("t5_t", 1'b1, 32'h0);
    bad_addr = 32'h0000_0008;
    #2 rst_n = 1'b0;
    #1 reset_vals("t6_async");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_addr", imem_addr_o, 32'd4);
    see("t6_c2", 1'b0, 32'd0);
    tick();
    see("t6_c3", 1'b1, 32'd0);
    tick();
    see("t6_c4", 1'b1, 32'd4);
`ifdef FETCH_ILLEGAL_CHK_EN
    chk("t6_ill_ok", 32'(illegal_o), 32'd0);
`endif
    tick();
    chk("t6_bad_valid", 32'(instr_valid_o), 32'd1);
    chk("t6_bad_pc", instr_pc_o, 32'd8);
`ifdef FETCH_ILLEGAL_CHK_EN
    chk("t6_bad_instr", instr_o, NOP);
    chk("t6_bad_ill", 32'(illegal_o), 32'd1);
`else
    chk("t6_bad_instr", instr_o, 32'h0000_0001);
`endif
    chk("no_overflow", 32'(ovf), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
